// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS-I subset datapath:
// FSM states, ALU operation encoding and opcode/funct field values.
package mips_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/mc_datapath_alu.sv
// Combinational ALU: wrap-around add/sub, bitwise and/or, signed set-less-than.
module alu
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  // Result select and zero flag
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
    zero = (y == '0);
  end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-I subset datapath: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing,
// internal register file (not cleared by reset), handshaked instruction and
// data memory ports.
module mc_datapath
  import mips_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              NREG     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            halted
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  state_e          r_state;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_aluout;
  logic [XLEN-1:0] r_mdr;
  logic            r_halted;
  logic [XLEN-1:0] r_rf [NREG];

  logic [5:0]      w_op;
  logic [5:0]      w_funct;
  logic [RW-1:0]   w_rs;
  logic [RW-1:0]   w_rt;
  logic [RW-1:0]   w_rd;
  logic            w_is_r;
  logic            w_is_jr;
  logic            w_is_ralu;
  logic            w_is_lw;
  logic            w_is_sw;
  logic            w_is_beq;
  logic            w_is_addi;
  logic            w_is_j;
  logic            w_legal;
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  logic [XLEN-1:0] w_alu_b;
  alu_op_e         w_alu_op;
  logic [XLEN-1:0] w_alu_y;
  logic            w_alu_zero;
  logic [RW-1:0]   w_wdst;
  logic [XLEN-1:0] w_wdata;
  logic            w_rf_we;

  assign w_op      = r_ir[31:26];
  assign w_funct   = r_ir[5:0];
  assign w_rs      = r_ir[21 +: RW];
  assign w_rt      = r_ir[16 +: RW];
  assign w_rd      = r_ir[11 +: RW];

  assign w_is_r    = (w_op == OP_RTYPE);
  assign w_is_jr   = w_is_r && (w_funct == FN_JR);
  assign w_is_ralu = w_is_r && ((w_funct == FN_ADD) || (w_funct == FN_SUB) ||
                                (w_funct == FN_AND) || (w_funct == FN_OR)  ||
                                (w_funct == FN_SLT));
  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_addi = (w_op == OP_ADDI);
  assign w_is_j    = (w_op == OP_J);
  assign w_legal   = w_is_ralu || w_is_jr || w_is_lw || w_is_sw ||
                     w_is_beq || w_is_addi || w_is_j;

  // Register 0 is never written, so force its read value rather than rely on storage
  assign w_rs_val  = (w_rs == '0) ? '0 : r_rf[w_rs];
  assign w_rt_val  = (w_rt == '0) ? '0 : r_rf[w_rt];

  assign w_alu_b   = (w_is_r || w_is_beq) ? r_b : r_imm;

  // ALU operation from opcode/funct; beq compares by subtraction
  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_is_beq) begin
      w_alu_op = ALU_SUB;
    end else if (w_is_r) begin
      case (w_funct)
        FN_SUB:  w_alu_op = ALU_SUB;
        FN_AND:  w_alu_op = ALU_AND;
        FN_OR:   w_alu_op = ALU_OR;
        FN_SLT:  w_alu_op = ALU_SLT;
        default: w_alu_op = ALU_ADD;
      endcase
    end
  end

  alu #(.XLEN(XLEN)) u_alu (
    .a    (r_a),
    .b    (w_alu_b),
    .op   (w_alu_op),
    .y    (w_alu_y),
    .zero (w_alu_zero)
  );

  assign w_wdst  = w_is_r ? w_rd : w_rt;
  assign w_wdata = w_is_lw ? r_mdr : r_aluout;
  assign w_rf_we = rst && (r_state == WB) && (w_wdst != '0);

  // Register file write port; contents survive reset
  always_ff @(posedge clk) begin
    if (w_rf_we) begin
      r_rf[w_wdst] <= w_wdata;
    end
  end

  // Main sequencer: one instruction through FETCH..WB, HALT on illegal encoding
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_imm    <= '0;
      r_aluout <= '0;
      r_mdr    <= '0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_pc    <= r_pc + XLEN'(4);
            r_state <= DECODE;
          end
        end
        DECODE: begin
          r_a   <= w_rs_val;
          r_b   <= w_rt_val;
          r_imm <= {{(XLEN-16){r_ir[15]}}, r_ir[15:0]};
          if (!w_legal) begin
            // PC already advanced past the bad word; point back at it
            r_pc     <= r_pc - XLEN'(4);
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_aluout <= w_alu_y;
          if (w_is_beq) begin
            if (w_alu_zero) begin
              r_pc <= r_pc + (r_imm << 2);
            end
            r_state <= FETCH;
          end else if (w_is_j) begin
            r_pc    <= {r_pc[XLEN-1:28], r_ir[25:0], 2'b00};
            r_state <= FETCH;
          end else if (w_is_jr) begin
            r_pc    <= r_a;
            r_state <= FETCH;
          end else if (w_is_lw || w_is_sw) begin
            r_state <= MEM;
          end else begin
            r_state <= WB;
          end
        end
        MEM: begin
          if (dmem_ack) begin
            r_mdr   <= dmem_rdata;
            r_state <= w_is_lw ? WB : FETCH;
          end
        end
        WB:      r_state <= FETCH;
        HALT:    r_state <= HALT;
        default: r_state <= FETCH;
      endcase
    end
  end

  assign imem_req   = rst && (r_state == FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = rst && (r_state == MEM);
  assign dmem_we    = dmem_req && w_is_sw;
  assign dmem_addr  = r_aluout;
  assign dmem_wdata = r_b;
  assign pc         = r_pc;
  assign halted     = r_halted;

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: expected fetch addresses and data
// transactions are queued by the stimulus; monitors pop and compare.
module tb_mc_datapath;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
    int unsigned dly;
  } dtx_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] pc;
  logic        halted;

  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic        imem_stall = 1'b0;

  logic [31:0] fq [$];
  dtx_t        dq [$];

  int n_vec  = 0;
  int n_miss = 0;

  // data-side monitor state
  logic        d_busy = 1'b0;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  int unsigned d_cyc;

  always #5 clk = ~clk;

  mc_datapath #(.XLEN(32), .NREG(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .pc         (pc),
    .halted     (halted)
  );

  assign imem_ack   = imem_req && !imem_stall;
  assign imem_rdata = imem[imem_addr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned cur_delay();
    return (dq.size() > 0) ? dq[0].dly : 0;
  endfunction

  task automatic push_d(input logic [31:0] a, input logic [31:0] d, input logic we,
                        input int unsigned dly);
    dtx_t e;
    e.addr = a; e.data = d; e.we = we; e.dly = dly;
    dq.push_back(e);
  endtask

  task automatic wait_drained(input int unsigned maxc, input string name);
    int unsigned c = 0;
    while ((fq.size() != 0 || dq.size() != 0) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk(name, fq.size() + dq.size(), 32'd0);
  endtask

  // Instruction-side monitor: each accepted fetch must match the next expected PC
  always @(negedge clk) begin
    if (rst && imem_req && imem_ack) begin
      if (fq.size() == 0) chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
      else                chk("fetch_addr", imem_addr, fq.pop_front());
    end
  end

  // Data-side responder and monitor: stall by the queued delay, check hold stability
  always @(negedge clk) begin
    chk("req_exclusive", {31'b0, imem_req & dmem_req}, 32'd0);
    if (rst && dmem_req) begin
      if (!d_busy) begin
        d_busy  = 1'b1;
        d_addr  = dmem_addr;
        d_wdata = dmem_wdata;
        d_we    = dmem_we;
        d_cyc   = 0;
      end else begin
        chk("dmem_addr_hold", dmem_addr, d_addr);
        chk("dmem_wdata_hold", dmem_wdata, d_wdata);
        chk("dmem_we_hold", {31'b0, dmem_we}, {31'b0, d_we});
      end
      d_cyc++;
      if (d_cyc > cur_delay()) begin
        dmem_ack   = 1'b1;
        dmem_rdata = dmem[dmem_addr[7:2]];
        if (dq.size() == 0) begin
          chk("unexpected_dmem", dmem_addr, 32'hFFFF_FFFF);
        end else begin
          dtx_t e;
          e = dq.pop_front();
          chk("dmem_addr", d_addr, e.addr);
          chk("dmem_we", {31'b0, d_we}, {31'b0, e.we});
          if (e.we) chk("dmem_wdata", d_wdata, e.data);
        end
      end else begin
        dmem_ack = 1'b0;
      end
    end else begin
      dmem_ack = 1'b0;
      d_busy   = 1'b0;
    end
  end

  // Data memory storage: commit writes on the accepting edge
  always @(posedge clk) begin
    if (rst && dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
  end

  initial begin
    int unsigned c;
    logic [31:0] prog_a [0:28];
    logic [31:0] exp_f  [0:25];

    for (int i = 0; i < 64; i++) begin
      imem[i] = 32'hFC00_0000;
      dmem[i] = '0;
    end

    // Program 1: beq $1,$1,-1 at 0x10 spins on itself
    imem[0] = 32'h2001_0003;  // addi $1,$0,3
    imem[1] = 32'h0800_0004;  // j 0x10
    imem[4] = 32'h1021_FFFF;  // beq $1,$1,-1

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'b0, dmem_we}, 32'd0);

    fq.push_back(32'h00); fq.push_back(32'h04);
    fq.push_back(32'h10); fq.push_back(32'h10); fq.push_back(32'h10);
    rst = 1'b1;
    wait_drained(200, "prog1_drain");

    // Hold the next fetch, then reset in the middle of the wait
    imem_stall = 1'b1;
    c = 0;
    while (!imem_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("stall_fetch_seen", {31'b0, imem_req}, 32'd1);
    rst = 1'b0;
    #1;
    chk("imem_req_gated_in_reset", {31'b0, imem_req}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("reset_pc_after_abort", pc, 32'h0);

    // Program 2: arithmetic, memory, branches, jumps, then illegal at 0x70
    prog_a = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hAC03_0004,
               32'h1022_0005, 32'h1021_0001, 32'hFC00_0000, 32'h2000_0009,
               32'h0000_2020, 32'hAC04_0008, 32'h8C05_0004, 32'h00A1_3022,
               32'h0026_382A, 32'h2008_FFFD, 32'h0101_482A, 32'h0062_5024,
               32'h0062_5825, 32'hAC07_000C, 32'hAC09_0010, 32'hAC0A_0014,
               32'hAC0B_0018, 32'hAC06_001C, 32'h0800_0018, 32'hFC00_0000,
               32'h200C_006C, 32'h0180_0008, 32'hFC00_0000, 32'hAC08_0020,
               32'hFC00_0000};
    for (int i = 0; i < 29; i++) imem[i] = prog_a[i];

    exp_f = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h1C, 32'h20,
              32'h24, 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40,
              32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h60, 32'h64,
              32'h6C, 32'h70};
    for (int i = 0; i < 26; i++) fq.push_back(exp_f[i]);

    push_d(32'd4,  32'd12,         1'b1, 3);  // sw $3,4($0): 3 wait cycles
    push_d(32'd8,  32'd0,          1'b1, 0);  // sw $4 after $0 write attempt
    push_d(32'd4,  32'd0,          1'b0, 2);  // lw $5,4($0)
    push_d(32'd12, 32'd1,          1'b1, 1);  // slt 5<7
    push_d(32'd16, 32'd1,          1'b1, 0);  // slt -3<5 signed
    push_d(32'd20, 32'd4,          1'b1, 1);  // 12 & 7
    push_d(32'd24, 32'd15,         1'b1, 0);  // 12 | 7
    push_d(32'd28, 32'd7,          1'b1, 1);  // lw result 12 - 5
    push_d(32'd32, 32'hFFFF_FFFD,  1'b1, 0);  // reached via jr

    @(posedge clk); @(negedge clk);
    imem_stall = 1'b0;
    rst = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rf3_at_cycle12", dut.r_rf[3], 32'd12);

    wait_drained(2000, "prog2_drain");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_req_when_halted", {30'b0, imem_req, dmem_req}, 32'd0);
    end
    chk("halted_flag", {31'b0, halted}, 32'd1);
    chk("halt_pc", pc, 32'h70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
